// File: rtl/line_buffer_pkg.sv
// Shared defaults and helpers for the multi-tap line buffer.
package line_buffer_pkg;

    localparam int LB_WIDTH = 35;
    localparam int LB_DEPTH = 1280;

    typedef logic [LB_WIDTH-1:0] pixel_t;

    // Width of a saturating counter that must reach taps*depth inclusive.
    function automatic int fill_width(input int taps, input int depth);
        return $clog2(taps * depth + 1);
    endfunction

endpackage

// File: rtl/line_buffer_ram.sv
// One DEPTH x WIDTH simple dual-port line RAM with a synchronous,
// old-data read port whose output register doubles as the tap register.
module line_buffer_ram
    import line_buffer_pkg::*;
#(
    parameter int WIDTH = LB_WIDTH,
    parameter int DEPTH = LB_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     en,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage write; no reset so the array stays a plain block RAM.
    // NOTE: memory arrays are never reset -- validity is tracked outside the RAM.
    always_ff @(posedge clk) begin
        if (en) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read: returns the pre-write contents, holds while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (clear) begin
            rdata <= '0;
        end else if (en) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/line_buffer_taps.sv
// Multi-tap line buffer: delays the accepted pixel stream by 1..TAPS lines
// of DEPTH samples each, with per-tap valid flags and a synchronous flush.
//
// Chaining detail: a synchronous RAM cannot hand its read data to the next
// RAM's write port in the same cycle, so RAM k>=1 is written from the
// registered tap k-1 one accepted sample later, at the previous pointer
// (wr_ptr). Every sample still arrives exactly (k+1)*DEPTH shifts later.
module line_buffer_taps
    import line_buffer_pkg::*;
#(
    parameter int WIDTH = LB_WIDTH,
    parameter int DEPTH = LB_DEPTH,
    parameter int TAPS  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    in_valid,
    input  logic [WIDTH-1:0]        data_in,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        data_d,
    output logic [TAPS*WIDTH-1:0]   taps_out,
    output logic [TAPS-1:0]         tap_valid
);

    localparam int PW = $clog2(DEPTH);
    localparam int FW = fill_width(TAPS, DEPTH);

    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [FW-1:0] FILL_MAX = FW'(TAPS * DEPTH);

    logic          accept;
    logic [PW-1:0] ptr;
    logic [PW-1:0] wr_ptr;
    logic [FW-1:0] fill;

    // clear wins over a simultaneous in_valid; that sample is dropped.
    assign accept = in_valid & ~clear;

    // Shared circular pointer, delayed write pointer and saturating fill count.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr    <= '0;
            wr_ptr <= PTR_LAST;
            fill   <= '0;
        end else if (clear) begin
            ptr    <= '0;
            wr_ptr <= PTR_LAST;
            fill   <= '0;
        end else if (accept) begin
            wr_ptr <= ptr;
            ptr    <= (ptr == PTR_LAST) ? '0 : ptr + PW'(1);
            fill   <= (fill == FILL_MAX) ? fill : fill + FW'(1);
        end
    end

    // Output strobe, delayed input copy and per-tap valid flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            data_d    <= '0;
            tap_valid <= '0;
        end else if (clear) begin
            out_valid <= 1'b0;
            data_d    <= '0;
            tap_valid <= '0;
        end else begin
            out_valid <= accept;
            if (accept) begin
                data_d <= data_in;
                for (int k = 0; k < TAPS; k++) begin
                    tap_valid[k] <= (fill >= FW'((k + 1) * DEPTH));
                end
            end
        end
    end

    for (genvar k = 0; k < TAPS; k++) begin : g_line
        logic [WIDTH-1:0] wdata;
        logic [PW-1:0]    waddr;
        logic [WIDTH-1:0] rdata;

        if (k == 0) begin : g_head
            assign wdata = data_in;
            assign waddr = ptr;
        end else begin : g_chain
            assign wdata = taps_out[(k-1)*WIDTH +: WIDTH];
            assign waddr = wr_ptr;
        end

        line_buffer_ram #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_ram (
            .clk   (clk),
            .rst_n (rst_n),
            .clear (clear),
            .en    (accept),
            .waddr (waddr),
            .raddr (ptr),
            .wdata (wdata),
            .rdata (rdata)
        );

        assign taps_out[k*WIDTH +: WIDTH] = rdata;
    end

endmodule

// File: tb/tb_line_buffer_taps.sv
// Self-checking bench for line_buffer_taps (WIDTH=8, DEPTH=4, TAPS=2).
// Stimulus pushes expected results into a queue; a monitor pops on out_valid.
module tb_line_buffer_taps;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int TAPS  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clear = 1'b0;
    logic              in_valid = 1'b0;
    logic [WIDTH-1:0]  data_in = '0;
    logic              out_valid;
    logic [WIDTH-1:0]  data_d;
    logic [TAPS*WIDTH-1:0] taps_out;
    logic [TAPS-1:0]   tap_valid;

    logic [WIDTH-1:0]  t0, t1;
    assign t0 = taps_out[7:0];
    assign t1 = taps_out[15:8];

    line_buffer_taps #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .TAPS  (TAPS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .data_in   (data_in),
        .out_valid (out_valid),
        .data_d    (data_d),
        .taps_out  (taps_out),
        .tap_valid (tap_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] v;
        logic [7:0] data;
        logic [7:0] t1;
        logic [7:0] t0;
    } exp_t;

    exp_t       sbq[$];
    logic [7:0] hist[$];
    exp_t       last_exp;
    int         tests = 0;
    int         failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: history of accepted samples since the last clear/reset.
    task automatic model_push(input logic [7:0] x);
        exp_t e;
        int   n;
        n      = hist.size();
        e.data = x;
        e.v[0] = (n >= DEPTH);
        e.v[1] = (n >= 2 * DEPTH);
        e.t0   = e.v[0] ? hist[n - DEPTH] : 8'h00;
        e.t1   = e.v[1] ? hist[n - 2 * DEPTH] : 8'h00;
        hist.push_back(x);
        if (hist.size() > 2 * DEPTH) void'(hist.pop_front());
        sbq.push_back(e);
        last_exp = e;
    endtask

    task automatic model_clear();
        hist.delete();
        last_exp = '0;
    endtask

    // One clock of stimulus; returns 1 time unit after the active edge.
    task automatic cycle(input logic v, input logic [7:0] x, input logic clr);
        @(negedge clk);
        in_valid = v;
        data_in  = x;
        clear    = clr;
        if (clr) model_clear();
        else if (v) model_push(x);
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string name);
        check({name, "_out_valid"}, {31'b0, out_valid}, 32'd0);
        check({name, "_outputs"}, {14'b0, tap_valid, taps_out}, 32'd0);
        check({name, "_data_d"}, {24'b0, data_d}, 32'd0);
    endtask

    task automatic check_hold(input string name);
        check({name, "_out_valid"}, {31'b0, out_valid}, 32'd0);
        check({name, "_data_d"}, {24'b0, data_d}, {24'b0, last_exp.data});
        check({name, "_tap_valid"}, {30'b0, tap_valid}, {30'b0, last_exp.v});
        if (last_exp.v[0]) check({name, "_t0"}, {24'b0, t0}, {24'b0, last_exp.t0});
        if (last_exp.v[1]) check({name, "_t1"}, {24'b0, t1}, {24'b0, last_exp.t1});
    endtask

    // Monitor: every presented output is matched against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (sbq.size() == 0) begin
                    check("spurious_out_valid", {31'b0, out_valid}, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    check("scoreboard",
                          {6'b0, tap_valid, data_d, e.v[1] ? t1 : 8'h00, e.v[0] ? t0 : 8'h00},
                          {6'b0, e.v, e.data, e.t1, e.t0});
                end
            end
        end
    end

    initial begin
        int gap;
        // ---- 1. reset, then reset mid-stream ----
        #12 rst_n = 1'b1;
        check_zero("after_por");
        for (int i = 1; i <= 3; i++) cycle(1'b1, 8'(i), 1'b0);
        @(negedge clk);
        #2;
        in_valid = 1'b1;
        data_in  = 8'hAA;
        rst_n    = 1'b0;
        sbq.delete();
        model_clear();
        #1;
        check_zero("async_reset");
        repeat (2) @(posedge clk);
        #1;
        check_zero("in_reset");
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        cycle(1'b0, 8'h00, 1'b0);
        check("post_reset_idle", {31'b0, out_valid}, 32'd0);
        cycle(1'b1, 8'd7, 1'b0);
        check("first_out_valid", {23'b0, out_valid, data_d}, {23'b0, 1'b1, 8'd7});

        // ---- 2. continuous feed 1..12 ----
        cycle(1'b0, 8'h00, 1'b1);
        check_zero("clear_before_feed");
        for (int i = 1; i <= 12; i++) begin
            cycle(1'b1, 8'(i), 1'b0);
            if (i == 4) check("cont_tv_at4", {30'b0, tap_valid}, 32'd0);
            if (i == 5) check("cont_tv0_rise", {14'b0, tap_valid, data_d, t0}, {14'b0, 2'b01, 8'd5, 8'd1});
            if (i == 8) check("cont_tv_at8", {30'b0, tap_valid}, 32'd1);
            if (i == 9) check("cont_tv1_rise", {6'b0, tap_valid, data_d, t1, t0}, {6'b0, 2'b11, 8'd9, 8'd1, 8'd5});
            if (i == 12) check("cont_at12", {16'b0, taps_out}, {16'b0, 8'd4, 8'd8});
        end

        // ---- 3. gapped feed ----
        cycle(1'b0, 8'h00, 1'b1);
        for (int i = 1; i <= 12; i++) begin
            cycle(1'b1, 8'(i), 1'b0);
            if (i == 5) check("gap_tv0_rise", {14'b0, tap_valid, data_d, t0}, {14'b0, 2'b01, 8'd5, 8'd1});
            if (i == 9) check("gap_tv1_rise", {6'b0, tap_valid, data_d, t1, t0}, {6'b0, 2'b11, 8'd9, 8'd1, 8'd5});
            if (i == 12) check("gap_at12", {16'b0, taps_out}, {16'b0, 8'd4, 8'd8});
            gap = (i % 3 == 1) ? 2 : $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                cycle(1'b0, 8'($urandom), 1'b0);
                check_hold("gap_hold");
            end
        end

        // ---- 4. wrap and saturation over 40 samples ----
        cycle(1'b0, 8'h00, 1'b1);
        for (int i = 1; i <= 40; i++) begin
            cycle(1'b1, 8'(100 + i), 1'b0);
            if (i == 8) check("sat_tv_at8", {30'b0, tap_valid}, 32'd1);
            if (i >= 9) check("sat_tv", {30'b0, tap_valid}, 32'd3);
        end

        // ---- 5. clear colliding with sample 6 ----
        cycle(1'b0, 8'h00, 1'b1);
        for (int i = 1; i <= 5; i++) cycle(1'b1, 8'(i), 1'b0);
        cycle(1'b1, 8'd6, 1'b1);
        check_zero("clear_collision");
        for (int i = 20; i <= 24; i++) begin
            cycle(1'b1, 8'(i), 1'b0);
            if (i <= 23) check("resume_tv", {30'b0, tap_valid}, 32'd0);
            else check("resume_t0", {22'b0, tap_valid, t0}, {22'b0, 2'b01, 8'd20});
        end

        // ---- 6. random stress ----
        for (int i = 0; i < 10000; i++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 199) == 0));
        end
        repeat (3) cycle(1'b0, 8'h00, 1'b0);
        check("scoreboard_drained", sbq.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
